// File: rtl/fft_out_serializer.sv
`timescale 1ns/1ps
// Serializes wide FFT output beats (LANES complex samples per beat) into a
// one-sample-per-handshake stream tagged with its FFT bin index.
module fft_out_serializer #(
    parameter int unsigned DW    = 13,
    parameter int unsigned LANES = 16,
    parameter int unsigned BEATS = 32,
    parameter int unsigned DEPTH = 32
) (
    input  logic                                       clk,
    input  logic                                       rstn,
    input  logic                                       valid_in,
    input  logic [LANES*DW-1:0]                        din_re_t,
    input  logic [LANES*DW-1:0]                        din_im_t,
    output logic                                       m_valid,
    input  logic                                       m_ready,
    output logic [DW-1:0]                              m_re,
    output logic [DW-1:0]                              m_im,
    output logic [$clog2(BEATS)+$clog2(LANES)-1:0]     m_idx,
    output logic                                       m_last,
    output logic                                       overflow
);

    localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned VW = LANES * DW;

    logic [CW-1:0] r_count;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_lane;
    logic [BW-1:0] r_beat_in;
    logic          r_overflow;

    logic [VW-1:0] r_mem_re  [DEPTH];
    logic [VW-1:0] r_mem_im  [DEPTH];
    logic [BW-1:0] r_mem_tag [DEPTH];

    logic          w_full;
    logic          w_handshake;
    logic          w_release;
    logic          w_accept;
    logic [VW-1:0] w_head_re;
    logic [VW-1:0] w_head_im;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_full      = (r_count == CW'(DEPTH));
    assign w_handshake = m_valid && m_ready;
    assign w_release   = w_handshake && (r_lane == LW'(LANES - 1));
    // A full buffer can still take a beat if the head leaves in the same cycle.
    assign w_accept    = valid_in && (!w_full || w_release);

    // Control state: occupancy, pointers, lane/beat counters, sticky overflow.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_lane     <= '0;
            r_beat_in  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (valid_in) begin
                r_beat_in <= (r_beat_in == BW'(BEATS - 1)) ? '0 : r_beat_in + BW'(1);
            end
            if (valid_in && !w_accept) begin
                r_overflow <= 1'b1;
            end
            if (w_accept) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_release) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_handshake) begin
                r_lane <= (r_lane == LW'(LANES - 1)) ? '0 : r_lane + LW'(1);
            end
            case ({w_accept, w_release})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Beat storage carries no reset; contents are only observed while occupied.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem_re[r_wr_ptr]  <= din_re_t;
            r_mem_im[r_wr_ptr]  <= din_im_t;
            r_mem_tag[r_wr_ptr] <= r_beat_in;
        end
    end

    assign w_head_re = r_mem_re[r_rd_ptr];
    assign w_head_im = r_mem_im[r_rd_ptr];

    always_comb begin
        m_re = w_head_re[DW-1:0];
        m_im = w_head_im[DW-1:0];
        for (int unsigned k = 0; k < LANES; k++) begin
            if (r_lane == LW'(k)) begin
                m_re = w_head_re[k*DW +: DW];
                m_im = w_head_im[k*DW +: DW];
            end
        end
    end

    assign m_valid  = (r_count != '0);
    assign m_idx    = {r_mem_tag[r_rd_ptr], r_lane};
    assign m_last   = m_valid && (m_idx == '1);
    assign overflow = r_overflow;

endmodule

// File: tb/tb_fft_out_serializer.sv
`timescale 1ns/1ps
// Directed bench for fft_out_serializer: scoreboard of expected samples,
// frame/backpressure/overflow/boundary/reset scenarios.
module tb_fft_out_serializer;

    localparam int unsigned DW    = 13;
    localparam int unsigned LANES = 16;
    localparam int unsigned VW    = LANES * DW;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic [8:0]    idx;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          valid_in;
    logic [VW-1:0] din_re_t;
    logic [VW-1:0] din_im_t;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_re;
    logic [DW-1:0] m_im;
    logic [8:0]    m_idx;
    logic          m_last;
    logic          overflow;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_samp   = 0;
    int   n_last   = 0;
    bit   mon_en   = 1'b0;
    bit   rand_ready = 1'b0;
    exp_t exp_q[$];
    exp_t mon_e;

    fft_out_serializer #(.DW(DW), .LANES(LANES), .BEATS(32), .DEPTH(32)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .valid_in (valid_in),
        .din_re_t (din_re_t),
        .din_im_t (din_im_t),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_re     (m_re),
        .m_im     (m_im),
        .m_idx    (m_idx),
        .m_last   (m_last),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; the next rising edge consumes them.
    task automatic tick();
        @(negedge clk);
        if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    endtask

    function automatic logic [VW-1:0] mk_re(input int b);
        logic [VW-1:0] v;
        for (int k = 0; k < LANES; k++) v[k*DW +: DW] = DW'(b * LANES + k);
        return v;
    endfunction

    function automatic logic [VW-1:0] mk_im(input int b);
        logic [VW-1:0] v;
        for (int k = 0; k < LANES; k++) v[k*DW +: DW] = DW'(-(b * LANES + k));
        return v;
    endfunction

    task automatic drive_beat(input logic [VW-1:0] re, input logic [VW-1:0] im,
                              input logic [4:0] tag, input bit acc);
        exp_t e;
        valid_in = 1'b1;
        din_re_t = re;
        din_im_t = im;
        if (acc) begin
            for (int k = 0; k < LANES; k++) begin
                e.re  = re[k*DW +: DW];
                e.im  = im[k*DW +: DW];
                e.idx = {tag, 4'(k)};
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic send_frame(input bit lat_chk);
        for (int b = 0; b < 32; b++) begin
            tick();
            if (lat_chk && b == 0) check("pre_valid", 32'(m_valid), 0);
            if (lat_chk && b == 1) begin
                check("first_valid", 32'(m_valid), 1);
                check("first_idx", 32'(m_idx), 0);
            end
            drive_beat(mk_re(b), mk_im(b), 5'(b), 1'b1);
        end
        tick();
        valid_in = 1'b0;
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && exp_q.size() != 0; i++) tick();
        check("drain_done", 32'(exp_q.size()), 0);
        check("drain_idle", 32'(m_valid), 0);
    endtask

    task automatic do_reset();
        tick();
        rstn     = 1'b0;
        valid_in = 1'b0;
        m_ready  = 1'b0;
        mon_en   = 1'b0;
        exp_q.delete();
        tick();
        rstn   = 1'b1;
        n_samp = 0;
        n_last = 0;
        mon_en = 1'b1;
    endtask

    // Sample after the falling-edge drive settles; a handshake here means the next edge consumes.
    always @(negedge clk) begin
        #2;
        if (mon_en && m_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 32'(m_valid), 0);
            end else begin
                mon_e = exp_q[0];
                check("re", 32'(m_re), 32'(mon_e.re));
                check("im", 32'(m_im), 32'(mon_e.im));
                check("idx", 32'(m_idx), 32'(mon_e.idx));
                check("last", 32'(m_last), 32'(mon_e.idx == 9'h1FF));
                if (m_ready) begin
                    void'(exp_q.pop_front());
                    n_samp++;
                    if (m_last) n_last++;
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VW-1:0] vr;
        logic [VW-1:0] vi;
        rstn = 1'b0; valid_in = 1'b0; m_ready = 1'b0;
        din_re_t = '0; din_im_t = '0;

        // Reset state
        tick(); tick();
        check("rst_valid", 32'(m_valid), 0);
        check("rst_last", 32'(m_last), 0);
        check("rst_ovf", 32'(overflow), 0);
        rstn = 1'b1;
        mon_en = 1'b1;

        // Full frame, always ready
        m_ready = 1'b1;
        send_frame(1'b1);
        drain(2000);
        check("f1_count", 32'(n_samp), 512);
        check("f1_last", 32'(n_last), 1);
        check("f1_ovf", 32'(overflow), 0);

        // Same frame with random backpressure
        n_samp = 0; n_last = 0;
        rand_ready = 1'b1;
        send_frame(1'b0);
        drain(5000);
        rand_ready = 1'b0;
        m_ready = 1'b1;
        check("f2_count", 32'(n_samp), 512);
        check("f2_ovf", 32'(overflow), 0);

        // Overflow: 33 beats with no drain
        do_reset();
        for (int b = 0; b < 32; b++) begin
            tick();
            drive_beat(mk_re(b), mk_im(b), 5'(b), 1'b1);
        end
        tick();
        check("ovf_at_full", 32'(overflow), 0);
        drive_beat(mk_re(32), mk_im(32), 5'd0, 1'b0);
        tick();
        valid_in = 1'b0;
        check("ovf_set", 32'(overflow), 1);
        check("ovf_valid", 32'(m_valid), 1);
        m_ready = 1'b1;
        drain(2000);
        check("ovf_count", 32'(n_samp), 512);
        check("ovf_sticky", 32'(overflow), 1);
        check("ovf_last", 32'(n_last), 1);

        // Write and release together at full
        do_reset();
        for (int b = 0; b < 32; b++) begin
            tick();
            drive_beat(mk_re(b), mk_im(b), 5'(b), 1'b1);
        end
        tick();
        valid_in = 1'b0;
        m_ready  = 1'b1;
        repeat (15) tick();
        check("full_lane15", 32'(m_idx), 32'(9'd15));
        drive_beat(mk_re(32), mk_im(32), 5'd0, 1'b1);
        tick();
        valid_in = 1'b0;
        check("full_ovf", 32'(overflow), 0);
        check("full_valid", 32'(m_valid), 1);
        drain(2000);
        check("full_count", 32'(n_samp), 33 * 16);
        check("full_ovf_end", 32'(overflow), 0);

        // Signed extremes on lane 3
        do_reset();
        vr = '0; vi = '0;
        vr[3*DW +: DW] = 13'h1000;
        vi[3*DW +: DW] = 13'h0FFF;
        tick();
        drive_beat(vr, vi, 5'd0, 1'b1);
        tick();
        valid_in = 1'b0;
        m_ready  = 1'b1;
        repeat (3) tick();
        m_ready = 1'b0;
        check("ext_idx", 32'(m_idx), 3);
        check("ext_re", 32'($signed(m_re)), 32'(-4096));
        check("ext_im", 32'($signed(m_im)), 32'(4095));
        tick();
        check("ext_hold_re", 32'($signed(m_re)), 32'(-4096));
        m_ready = 1'b1;
        drain(200);

        // Reset mid-drain, then a fresh frame
        do_reset();
        m_ready = 1'b1;
        send_frame(1'b0);
        for (int i = 0; i < 2000 && n_samp < 200; i++) tick();
        check("mid_samples", 32'(n_samp), 200);
        rstn    = 1'b0;
        mon_en  = 1'b0;
        exp_q.delete();
        tick();
        rstn = 1'b1;
        check("mid_rst_valid", 32'(m_valid), 0);
        check("mid_rst_ovf", 32'(overflow), 0);
        check("mid_rst_last", 32'(m_last), 0);
        n_samp = 0; n_last = 0;
        mon_en = 1'b1;
        send_frame(1'b1);
        drain(2000);
        check("mid_count", 32'(n_samp), 512);
        check("mid_last", 32'(n_last), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fft_out_serializer.md
FFT_OUT_SERIALIZER -- requirements
Module: fft_out_serializer

Interface
REQ-001: Parameter DW, default 13, output sample width per real/imag component.
REQ-002: Parameter LANES, default 16, samples per input beat.
REQ-003: Parameter BEATS, default 32, beats per FFT frame (LANES*BEATS = 512 points).
REQ-004: Parameter DEPTH, default 32, beat buffer capacity in beats.
REQ-005: clk  input  1  sole clock, all logic on rising edge.
REQ-006: rstn  input  1  reset, synchronous, active-low.
REQ-007: valid_in  input  1  FFT output beat valid, no backpressure toward FFT.
REQ-008: din_re_t  input  LANES*DW  real parts, lane k at bits [k*DW+DW-1 : k*DW], two's complement.
REQ-009: din_im_t  input  LANES*DW  imaginary parts, same packing.
REQ-010: m_valid  output  1  serial sample valid.
REQ-011: m_ready  input  1  downstream accept.
REQ-012: m_re  output  DW  serial real sample, signed.
REQ-013: m_im  output  DW  serial imaginary sample, signed.
REQ-014: m_idx  output  9  FFT bin index of presented sample, {beat_no[4:0], lane[3:0]}.
REQ-015: m_last  output  1  high when m_idx == 511.
REQ-016: overflow  output  1  sticky, beat dropped because buffer full.

Function
REQ-017: Input beat counter (5 bits) SHALL increment on every cycle with valid_in=1, including dropped beats, wrapping 31 -> 0; gaps in valid_in SHALL not clear it.
REQ-018: Each accepted beat SHALL be stored in a FIFO together with its beat counter value.
REQ-019: A beat SHALL be accepted when valid_in=1 and (occupancy < DEPTH or the head beat is released the same cycle).
REQ-020: Head release SHALL occur when m_valid=1, m_ready=1 and output lane counter == LANES-1.
REQ-021: A beat arriving when occupancy == DEPTH with no same-cycle release SHALL be dropped, and overflow SHALL set to 1 the following cycle and remain 1 until reset.
REQ-022: m_valid SHALL equal (occupancy != 0); m_re/m_im/m_idx/m_last SHALL reflect head beat at the current lane, combinationally from stored state.
REQ-023: Latency: beat written at edge N into an empty FIFO SHALL present lane 0 with m_valid=1 in the cycle after edge N.
REQ-024: Lane counter SHALL advance on each m_valid&&m_ready handshake, wrapping LANES-1 -> 0 on head release.
REQ-025: While m_valid=1 and m_ready=0, m_re, m_im, m_idx, m_last SHALL hold stable.
REQ-026: Simultaneous write and release at full SHALL keep occupancy at DEPTH with no overflow.
REQ-027: Simultaneous write and release at occupancy 1 SHALL present the new beat's lane 0 the next cycle with no m_valid bubble.
REQ-028: Samples SHALL pass unmodified (no rounding, saturation or reordering); output order is lane 0..15 within beat, beats in arrival order.

Reset
REQ-029: While rstn=0 at a rising edge: occupancy, read/write pointers, lane counter, input beat counter and overflow SHALL clear to 0; m_valid=0, m_last=0 the following cycle.
REQ-030: Buffer data storage SHALL not require reset; m_re/m_im/m_idx are don't-care while m_valid=0.
REQ-031: Reset asserted mid-drain SHALL discard all buffered beats; first valid_in after reset SHALL be beat 0.

Verification
REQ-032: One frame, 32 contiguous beats, lane k of beat b real = b*16+k, imag = -(b*16+k), m_ready=1 -> 512 samples in order, m_idx == m_re, m_last only on idx 511, first m_valid one cycle after first valid_in, overflow=0.
REQ-033: Same frame, m_ready random 50% -> identical sample sequence, outputs stable during stalls, no loss.
REQ-034: m_ready=0, 33 beats sent -> occupancy 32, 33rd beat dropped, overflow=1; then m_ready=1 -> exactly 512 samples out, idx 0..511, beat 32 (counter wrapped to 0) absent.
REQ-035: FIFO full, drain lane 15 of head in the same cycle a new beat arrives -> beat accepted, overflow stays 0, total samples = 33*16.
REQ-036: Lane 3 real input 13'h1000, imag 13'h0FFF -> m_re = -4096, m_im = 4095 at idx 3.
REQ-037: rstn=0 for one cycle after 200 samples drained -> m_valid=0 next cycle, overflow=0; a following frame restarts at idx 0.
